mem_dump_reader: RTL and testbench

- Reads a contiguous window of the processor's data RAM once the processor has finished executing.
- Serialises each word into bytes and presents them on a valid/ready byte stream, which feeds the host-side UART or the simulation file dumper.
- The processor writes results into data RAM; this block is the reader at the other end of that memory interface.
- Sits beside the processor core on the RAM's second (read) port.

---
 rtl/mem_dump_reader_if.sv | 52 +++++
 rtl/mem_dump_reader.sv | 170 +++++++++++++++++
 tb/tb_mem_dump_reader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_reader_if.sv
// Bus bundle for mem_dump_reader.
// Groups three sets of signals:
//   - the dump request: start, start_addr, length;
//   - the RAM read port: mem_rd_en, mem_addr, mem_rdata;
//   - the byte stream and status: out_data, out_valid, out_ready, out_last,
//     busy, done.
// Modports:
//   master - the reader. It drives the RAM strobe/address, the byte stream
//            and the status flags.
//   slave  - the environment. It issues requests, returns RAM data and
//            consumes the byte stream.
interface mem_dump_reader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  length;

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  logic                  busy;
  logic                  done;

  modport master (
    input  start, start_addr, length,
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output out_data, out_valid, out_last,
    input  out_ready,
    output busy, done
  );

  modport slave (
    output start, start_addr, length,
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  out_data, out_valid, out_last,
    output out_ready,
    input  busy, done
  );

endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
// Reads a contiguous window of data RAM after the processor halts. Each word
// is serialised least-significant byte first onto a valid/ready byte stream.
// Ports:
//   clk    - system clock; all state changes on the rising edge.
//   reset  - asynchronous, active-low reset.
//   bus    - mem_dump_reader_if.master:
//            start/start_addr/length  dump request (sampled only in IDLE)
//            mem_rd_en/mem_addr       RAM read strobe and word address
//            mem_rdata                RAM data, valid one cycle after the strobe
//            out_data/out_valid/out_ready/out_last  byte stream
//            busy/done                status (busy whenever not IDLE, done pulse)
// Every output is a register. The output logic computes the value for the
// coming state, so each output lines up with the state it belongs to.
module mem_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_dump_reader_if.master bus
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr,      addr_n;
  logic [LEN_WIDTH-1:0]  remaining, remaining_n;
  logic [DATA_WIDTH-1:0] word_buf,  word_buf_n;
  logic [IDX_WIDTH-1:0]  byte_idx,  byte_idx_n;

  logic       mem_rd_en_n;
  logic       out_valid_n;
  logic       out_last_n;
  logic       busy_n;
  logic       done_n;
  logic [7:0] out_data_n;

  logic handshake_c;
  logic word_end_c;
  logic start_ok_c;

  // A byte is transferred in SEND when valid and ready meet at the edge.
  assign handshake_c = (state == ST_SEND) && bus.out_valid && bus.out_ready;
  assign word_end_c  = handshake_c && (byte_idx == LAST_IDX);
  assign start_ok_c  = bus.start && (bus.length != '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = (bus.length != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: state_n = ST_WAIT;
      ST_WAIT: state_n = ST_SEND;
      ST_SEND: begin
        if (word_end_c) begin
          state_n = (remaining > LEN_WIDTH'(1)) ? ST_READ : ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output and datapath logic: computes the next value of every register.
  always_comb begin
    addr_n      = addr;
    remaining_n = remaining;
    word_buf_n  = word_buf;
    byte_idx_n  = byte_idx;

    unique case (state)
      ST_IDLE: begin
        if (start_ok_c) begin
          addr_n      = bus.start_addr;
          remaining_n = bus.length;
        end
      end
      ST_WAIT: begin
        // RAM data is valid only here; it is ignored in every other state.
        word_buf_n = bus.mem_rdata;
        byte_idx_n = '0;
      end
      ST_SEND: begin
        if (handshake_c) begin
          byte_idx_n = byte_idx + IDX_WIDTH'(1);
          if (word_end_c && (remaining > LEN_WIDTH'(1))) begin
            addr_n      = addr + ADDR_WIDTH'(1);
            remaining_n = remaining - LEN_WIDTH'(1);
          end
        end
      end
      default: begin
      end
    endcase

    mem_rd_en_n = (state_n == ST_READ);
    out_valid_n = (state_n == ST_SEND);
    busy_n      = (state_n != ST_IDLE);
    done_n      = (state_n == ST_DONE);
    // Last-word detection relies on remaining never being decremented below 1.
    out_last_n  = (state_n == ST_SEND) && (byte_idx_n == LAST_IDX) &&
                  (remaining_n == LEN_WIDTH'(1));

    // Little-endian byte select; hold the last byte when not presenting.
    out_data_n = bus.out_data;
    if (state_n == ST_SEND) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (byte_idx_n == IDX_WIDTH'(b)) begin
          out_data_n = word_buf_n[8*b +: 8];
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr          <= '0;
      remaining     <= '0;
      word_buf      <= '0;
      byte_idx      <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      addr          <= addr_n;
      remaining     <= remaining_n;
      word_buf      <= word_buf_n;
      byte_idx      <= byte_idx_n;
      bus.mem_rd_en <= mem_rd_en_n;
      bus.mem_addr  <= addr_n;
      bus.out_data  <= out_data_n;
      bus.out_valid <= out_valid_n;
      bus.out_last  <= out_last_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader. A RAM array answers the read port. The expected
// byte stream is built from the array contents with plain arithmetic.
module tb_mem_dump_reader;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned NB = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  // RAM answers one cycle after the strobe; otherwise the data bus carries noise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    else               bus.mem_rdata <= DW'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [AW-1:0] a, input int len);
    for (int i = 0; i < len; i++) ram[AW'(a + AW'(i))] = DW'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, bus.mem_rd_en, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"},  bus.out_last, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_done"},  bus.done, 0);
  endtask

  // ready_mode: 0 = always ready, 1 = random ready, 2 = 3-cycle stall on byte 1.
  task automatic run_dump(input logic [AW-1:0] a, input int len,
                          input int ready_mode, input bit inject_start);
    logic [7:0]    exp_q[$];
    logic [DW-1:0] w;
    logic [AW-1:0] exp_rd_addr;
    logic [7:0]    prev_data;
    logic          prev_last;
    bit            prev_stall;
    bit            finished;
    int            c, c_done, rd_count, hs_count, stalls, bound;

    for (int i = 0; i < len; i++) begin
      w = ram[AW'(a + AW'(i))];
      for (int b = 0; b < int'(NB); b++) exp_q.push_back(w[8*b +: 8]);
    end

    exp_rd_addr = a;
    c_done      = (len == 0) ? 1 : -1;
    rd_count    = 0;
    hs_count    = 0;
    stalls      = 0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_last   = 1'b0;
    finished    = 1'b0;
    bound       = 40 * len + 20;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.length     = LW'(len);
    bus.out_ready  = 1'b1;

    c = 0;
    while (!finished) begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      if (inject_start && c == 5) begin
        bus.start      = 1'b1;
        bus.start_addr = a + 16'h0100;
        bus.length     = LW'(3);
      end

      case (ready_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.out_valid && hs_count == 1 && stalls < 3) begin
            bus.out_ready = 1'b0;
            stalls++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase

      if (c == 1) check("rd_en_first", bus.mem_rd_en, (len != 0));
      if (c == 3 && len != 0) check("first_valid", bus.out_valid, 1);
      if (len == 0) check("zero_len_valid", bus.out_valid, 0);

      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_last", bus.out_last, prev_last);
      end

      check("busy", bus.busy, (c_done < 0) || (c <= c_done));
      check("done", bus.done, (c == c_done));

      if (bus.mem_rd_en) begin
        rd_count++;
        check("rd_addr", bus.mem_addr, exp_rd_addr);
        exp_rd_addr = exp_rd_addr + AW'(1);
      end

      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 1, 0);
        end else begin
          check("byte", bus.out_data, exp_q.pop_front());
          check("last", bus.out_last, (exp_q.size() == 0));
          hs_count++;
          if (exp_q.size() == 0) c_done = c + 1;
        end
      end

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;

      if (c_done > 0 && c >= c_done + 1) begin
        finished = 1'b1;
      end else if (c > bound) begin
        check("timeout", 0, 1);
        finished = 1'b1;
      end
    end

    check("rd_count", rd_count, len);
    check("byte_count", hs_count, len * NB);
    if (ready_mode == 0 && len != 0) check("done_cycle", c_done, 1 + len * (NB + 2));
    if (ready_mode == 2) check("stall_cycles", stalls, 3);
  endtask

  initial begin
    logic [AW-1:0] a;
    int            len;
    int            mode;

    bus.start      = 1'b1;
    bus.start_addr = 16'h0040;
    bus.length     = LW'(2);
    bus.out_ready  = 1'b1;

    // Reset held with start asserted: everything stays quiet.
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_addr", bus.mem_addr, 0);
    check("rst_data", bus.out_data, 0);
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("post_rst");
    end

    // Single word, continuous ready.
    ram[16'h0010] = 32'hDEADBEEF;
    run_dump(16'h0010, 1, 0, 1'b0);

    // Same word, with back-pressure on the second byte.
    run_dump(16'h0010, 1, 2, 1'b0);

    // Address wrap across the top of the RAM.
    ram[16'hFFFF] = 32'h04030201;
    ram[16'h0000] = 32'h08070605;
    run_dump(16'hFFFF, 2, 0, 1'b0);

    // Zero length: done only.
    run_dump(16'h1234, 0, 0, 1'b0);

    // Start while busy is ignored.
    fill(16'h0200, 4);
    run_dump(16'h0200, 4, 0, 1'b1);

    // Reset mid-dump, during the second byte of a 3-word dump.
    fill(16'h0300, 3);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = 16'h0300;
    bus.length     = LW'(3);
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'h0300;
    check("mid_byte1", bus.out_data, ram[a][15:8]);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("rst_hold");
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("rst_rel");
    end
    fill(16'h0500, 2);
    run_dump(16'h0500, 2, 0, 1'b0);

    // Randomised dumps.
    for (int n = 0; n < 12; n++) begin
      a    = AW'($urandom);
      if ($urandom_range(0, 2) == 0) a = 16'hFFFF - AW'($urandom_range(0, 3));
      len  = $urandom_range(1, 5);
      mode = $urandom_range(0, 1);
      fill(a, len);
      run_dump(a, len, mode, (len >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
